// File: rtl/fmrv32im_axim_pkg.sv
// Shared types and constants for the AXI4 master burst engine.
package fmrv32im_axim_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_ADDR = 3'd1,
    W_DATA = 3'd2,
    W_RESP = 3'd3,
    R_ADDR = 3'd4,
    R_DATA = 3'd5
  } axim_state_t;

  // Fixed AXI attributes, tied off in the integration wrapper.
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_WSTRB_ALL  = 4'b1111;

  // Beats in the next burst: limited by words left, the burst cap and the
  // distance to the next 4 KB page (a burst must never cross a page).
  function automatic logic [8:0] burst_words(input logic [13:0] rem_words,
                                             input logic [9:0]  page_word,
                                             input logic [8:0]  max_beats);
    logic [13:0] n;
    logic [13:0] to_page;
    n       = rem_words;
    to_page = 14'd1024 - {4'd0, page_word};
    if (n > {5'd0, max_beats}) n = {5'd0, max_beats};
    if (n > to_page)           n = to_page;
    return n[8:0];
  endfunction

endpackage

// File: rtl/fmrv32im_axim_wbuf.sv
// Two-entry FIFO holding prefetched write-back words ahead of the W channel.
module fmrv32im_axim_wbuf (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic [31:0] head_data,
  output logic [1:0]  count
);

  logic [31:0] entry [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  cnt;

  // Pointer and occupancy bookkeeping; reset empties the buffer.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Data storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge CLK) begin
    if (push) entry[wr_ptr] <= push_data;
  end

  assign head_data = entry[rd_ptr];
  assign count     = cnt;

endmodule

// File: rtl/fmrv32im_axim.sv
// AXI4 master moving word blocks between local memory and AXI: write-back
// (local -> AXI) and fill (AXI -> local), split into page-safe bursts.
module fmrv32im_axim
  import fmrv32im_axim_pkg::*;
#(
  parameter int unsigned MAX_BEATS = 256
) (
  input  logic        CLK,
  input  logic        RST_N,

  input  logic        WR_REQ_START,
  input  logic [31:0] WR_REQ_ADDR,
  input  logic [15:0] WR_REQ_LEN,
  output logic        WR_REQ_READY,
  output logic [9:0]  WR_REQ_MEM_ADDR,
  input  logic [31:0] WR_REQ_MEM_WDATA,

  input  logic        RD_REQ_START,
  input  logic [31:0] RD_REQ_ADDR,
  input  logic [15:0] RD_REQ_LEN,
  output logic        RD_REQ_READY,
  output logic        RD_REQ_MEM_WE,
  output logic [9:0]  RD_REQ_MEM_ADDR,
  output logic [31:0] RD_REQ_MEM_RDATA,

  output logic [31:0] M_AXI_AWADDR,
  output logic [7:0]  M_AXI_AWLEN,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic        M_AXI_WLAST,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,

  output logic [31:0] M_AXI_ARADDR,
  output logic [7:0]  M_AXI_ARLEN,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic        M_AXI_RLAST,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  axim_state_t state, state_n;

  logic        ready_q;
  logic [31:0] addr_q;
  logic [13:0] rem_q;
  logic [8:0]  beats_q;
  logic [13:0] fetch_q;
  logic [9:0]  wr_idx_q;
  logic [9:0]  rd_idx_q;
  logic        pend_q;

  logic [8:0]  burst;
  logic        addr_phase;
  logic        aw_hs;
  logic        ar_hs;
  logic        w_pop;
  logic        fetch_en;
  logic [2:0]  occ;
  logic [31:0] buf_head;
  logic [1:0]  buf_count;

  logic        unused_ok;
  assign unused_ok = &{1'b0, M_AXI_RLAST, WR_REQ_LEN[1:0], RD_REQ_LEN[1:0]};

  assign burst      = burst_words(rem_q, addr_q[11:2], 9'(MAX_BEATS));
  assign addr_phase = (state == W_ADDR) || (state == W_DATA);
  assign aw_hs      = M_AXI_AWVALID && M_AXI_AWREADY;
  assign ar_hs      = M_AXI_ARVALID && M_AXI_ARREADY;
  assign w_pop      = M_AXI_WVALID && M_AXI_WREADY;

  // Words in the buffer plus the one read still in flight from memory; a new
  // read is issued only if it will find a free slot when its data lands.
  assign occ      = {1'b0, buf_count} + {2'b00, pend_q};
  assign fetch_en = addr_phase && (fetch_q != '0) &&
                    ((occ < 3'd2) || ((occ == 3'd2) && w_pop));

  fmrv32im_axim_wbuf u_wbuf (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push      (pend_q),
    .push_data (WR_REQ_MEM_WDATA),
    .pop       (w_pop),
    .head_data (buf_head),
    .count     (buf_count)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state decode; a write START takes priority over a read START.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (WR_REQ_START)      state_n = W_ADDR;
        else if (RD_REQ_START) state_n = R_ADDR;
      end
      W_ADDR: begin
        if (rem_q == '0)   state_n = IDLE;
        else if (aw_hs)    state_n = W_DATA;
      end
      W_DATA: begin
        if (w_pop && (beats_q == 9'd1)) state_n = W_RESP;
      end
      W_RESP: begin
        if (M_AXI_BVALID) state_n = (rem_q == '0) ? IDLE : W_ADDR;
      end
      R_ADDR: begin
        if (rem_q == '0)   state_n = IDLE;
        else if (ar_hs)    state_n = R_DATA;
      end
      R_DATA: begin
        if (M_AXI_RVALID && (beats_q == 9'd1)) state_n = R_ADDR;
      end
      default: state_n = IDLE;
    endcase
  end

  // Burst bookkeeping, prefetch index and registered READY.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ready_q  <= 1'b1;
      addr_q   <= '0;
      rem_q    <= '0;
      beats_q  <= '0;
      fetch_q  <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      ready_q <= (state_n == IDLE);
      pend_q  <= fetch_en;
      if (fetch_en) begin
        wr_idx_q <= wr_idx_q + 10'd1;
        fetch_q  <= fetch_q - 14'd1;
      end
      case (state)
        IDLE: begin
          if (WR_REQ_START) begin
            addr_q   <= WR_REQ_ADDR;
            rem_q    <= WR_REQ_LEN[15:2];
            fetch_q  <= WR_REQ_LEN[15:2];
            wr_idx_q <= '0;
          end else if (RD_REQ_START) begin
            addr_q   <= RD_REQ_ADDR;
            rem_q    <= RD_REQ_LEN[15:2];
            rd_idx_q <= '0;
          end
        end
        W_ADDR, R_ADDR: begin
          if (aw_hs || ar_hs) begin
            beats_q <= burst;
            rem_q   <= rem_q - {5'd0, burst};
            addr_q  <= addr_q + {21'd0, burst, 2'b00};
          end
        end
        W_DATA: begin
          if (w_pop) beats_q <= beats_q - 9'd1;
        end
        R_DATA: begin
          if (M_AXI_RVALID) begin
            beats_q  <= beats_q - 9'd1;
            rd_idx_q <= rd_idx_q + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign WR_REQ_READY = ready_q;
  assign RD_REQ_READY = ready_q;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWLEN   = 8'(burst - 9'd1);
  assign M_AXI_AWVALID = (state == W_ADDR) && (rem_q != '0);
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARLEN   = 8'(burst - 9'd1);
  assign M_AXI_ARVALID = (state == R_ADDR) && (rem_q != '0);

  // Prefetched words for the next burst may sit in the buffer during
  // W_RESP/W_ADDR; they are presented only once their burst is in W_DATA.
  assign M_AXI_WVALID = (state == W_DATA) && (buf_count != '0);
  assign M_AXI_WDATA  = buf_head;
  assign M_AXI_WLAST  = (beats_q == 9'd1);
  assign M_AXI_BREADY = (state == W_RESP);

  assign M_AXI_RREADY     = (state == R_DATA);
  assign RD_REQ_MEM_WE    = M_AXI_RVALID && M_AXI_RREADY;
  assign RD_REQ_MEM_RDATA = M_AXI_RDATA;

  // Both memory addresses are zero when unused: the memory ORs them.
  assign WR_REQ_MEM_ADDR = addr_phase ? wr_idx_q : '0;
  assign RD_REQ_MEM_ADDR = (state == R_DATA) ? rd_idx_q : '0;

endmodule

// File: tb/tb_fmrv32im_axim.sv
// Randomized bench for fmrv32im_axim: random AXI slave timing, a local
// memory model and a burst-level reference model of the expected traffic.
module tb_fmrv32im_axim;

  logic        CLK;
  logic        RST_N;
  logic        WR_REQ_START, RD_REQ_START;
  logic [31:0] WR_REQ_ADDR, RD_REQ_ADDR;
  logic [15:0] WR_REQ_LEN, RD_REQ_LEN;
  logic        WR_REQ_READY, RD_REQ_READY;
  logic [9:0]  WR_REQ_MEM_ADDR, RD_REQ_MEM_ADDR;
  logic [31:0] WR_REQ_MEM_WDATA, RD_REQ_MEM_RDATA;
  logic        RD_REQ_MEM_WE;
  logic [31:0] M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_RDATA;
  logic [7:0]  M_AXI_AWLEN, M_AXI_ARLEN;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WLAST, M_AXI_WVALID;
  logic        M_AXI_WREADY, M_AXI_BVALID, M_AXI_BREADY;
  logic        M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RLAST, M_AXI_RVALID;
  logic        M_AXI_RREADY;

  fmrv32im_axim #(.MAX_BEATS(256)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .WR_REQ_START(WR_REQ_START), .WR_REQ_ADDR(WR_REQ_ADDR), .WR_REQ_LEN(WR_REQ_LEN),
    .WR_REQ_READY(WR_REQ_READY), .WR_REQ_MEM_ADDR(WR_REQ_MEM_ADDR),
    .WR_REQ_MEM_WDATA(WR_REQ_MEM_WDATA),
    .RD_REQ_START(RD_REQ_START), .RD_REQ_ADDR(RD_REQ_ADDR), .RD_REQ_LEN(RD_REQ_LEN),
    .RD_REQ_READY(RD_REQ_READY), .RD_REQ_MEM_WE(RD_REQ_MEM_WE),
    .RD_REQ_MEM_ADDR(RD_REQ_MEM_ADDR), .RD_REQ_MEM_RDATA(RD_REQ_MEM_RDATA),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] mem [1024];
  logic [39:0] exp_aw[$];
  logic [39:0] exp_ar[$];
  logic [32:0] exp_w[$];

  int unsigned pend_b, r_pend, we_cnt, exp_rd_idx;
  bit          b_hs, r_hs, aw_wait, ar_wait;
  logic [39:0] aw_prev, ar_prev;
  logic [31:0] cur_rdata;
  logic [9:0]  mem_a;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: expected address-phase bursts (and write beats) for a
  // request, derived directly from the burst-splitting rules.
  task automatic build_exp(input bit is_wr, input logic [31:0] addr, input int unsigned len);
    int unsigned words, n, room, idx;
    logic [31:0] a;
    words = len / 4;
    a     = addr;
    idx   = 0;
    while (words > 0) begin
      room = (4096 - (a % 4096)) / 4;
      n = words;
      if (n > 256)  n = 256;
      if (n > room) n = room;
      if (is_wr) begin
        exp_aw.push_back({a, 8'(n - 1)});
        for (int unsigned j = 0; j < n; j++) begin
          exp_w.push_back({(j == n - 1), mem[idx % 1024]});
          idx++;
        end
      end else begin
        exp_ar.push_back({a, 8'(n - 1)});
      end
      a     = a + 4 * n;
      words = words - n;
    end
  endtask

  // AXI slave, local memory read port and protocol monitor. Observes at the
  // falling edge, drives new inputs just after the rising edge.
  initial begin : slave
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_ARREADY = 0;
    M_AXI_RVALID = 0; M_AXI_RDATA = '0; M_AXI_RLAST = 0; WR_REQ_MEM_WDATA = '0;
    pend_b = 0; r_pend = 0; b_hs = 0; r_hs = 0; aw_wait = 0; ar_wait = 0;
    cur_rdata = '0; aw_prev = '0; ar_prev = '0;
    forever begin
      @(negedge CLK);
      mem_a = WR_REQ_MEM_ADDR;
      if (aw_wait) check("aw_hold", {M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWLEN}, {1'b1, aw_prev});
      if (ar_wait) check("ar_hold", {M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARLEN}, {1'b1, ar_prev});
      aw_wait = M_AXI_AWVALID && !M_AXI_AWREADY;
      ar_wait = M_AXI_ARVALID && !M_AXI_ARREADY;
      aw_prev = {M_AXI_AWADDR, M_AXI_AWLEN};
      ar_prev = {M_AXI_ARADDR, M_AXI_ARLEN};
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
        else check("aw", {M_AXI_AWADDR, M_AXI_AWLEN}, exp_aw.pop_front());
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        if (exp_w.size() == 0) check("w_unexpected", 1, 0);
        else check("w_last_data", {M_AXI_WLAST, M_AXI_WDATA}, exp_w.pop_front());
        if (M_AXI_WLAST) pend_b++;
      end
      if (M_AXI_BVALID && M_AXI_BREADY) begin
        b_hs = 1;
        pend_b--;
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        if (exp_ar.size() == 0) check("ar_unexpected", 1, 0);
        else check("ar", {M_AXI_ARADDR, M_AXI_ARLEN}, exp_ar.pop_front());
        r_pend += M_AXI_ARLEN + 1;
      end
      if (M_AXI_RVALID && M_AXI_RREADY) begin
        check("we", RD_REQ_MEM_WE, 1);
        check("we_addr", RD_REQ_MEM_ADDR, exp_rd_idx % 1024);
        check("we_data", RD_REQ_MEM_RDATA, cur_rdata);
        exp_rd_idx++;
        we_cnt++;
        r_pend--;
        r_hs = 1;
      end else if (RD_REQ_MEM_WE) begin
        check("we_spurious", 1, 0);
      end
      if (!M_AXI_RREADY && RD_REQ_MEM_ADDR != 0) check("rd_mem_addr_idle", RD_REQ_MEM_ADDR, 0);
      if (WR_REQ_READY && WR_REQ_MEM_ADDR != 0) check("wr_mem_addr_idle", WR_REQ_MEM_ADDR, 0);

      @(posedge CLK);
      #1;
      WR_REQ_MEM_WDATA = mem[mem_a];
      M_AXI_AWREADY = ($urandom_range(0, 3) != 0);
      M_AXI_ARREADY = ($urandom_range(0, 3) != 0);
      M_AXI_WREADY  = ($urandom_range(0, 2) != 0);
      if (b_hs) begin M_AXI_BVALID = 0; b_hs = 0; end
      if (!M_AXI_BVALID && pend_b > 0 && $urandom_range(0, 1) == 1) M_AXI_BVALID = 1;
      if (r_hs) begin M_AXI_RVALID = 0; M_AXI_RLAST = 0; r_hs = 0; end
      if (!M_AXI_RVALID && r_pend > 0 && $urandom_range(0, 3) != 0) begin
        cur_rdata    = $urandom;
        M_AXI_RDATA  = cur_rdata;
        M_AXI_RVALID = 1;
        M_AXI_RLAST  = (r_pend == 1);
      end
    end
  end

  task automatic wait_idle(input int unsigned budget);
    for (int unsigned c = 0; c < budget; c++) begin
      @(negedge CLK);
      if (WR_REQ_READY && RD_REQ_READY) return;
    end
    check("idle_timeout", 0, 1);
  endtask

  task automatic run_xfer(input bit do_wr, input bit do_rd, input logic [31:0] addr,
                          input int unsigned len);
    if (do_wr) build_exp(1, addr, len);
    else if (do_rd) build_exp(0, addr, len);
    we_cnt = 0;
    exp_rd_idx = 0;
    @(negedge CLK);
    WR_REQ_START = do_wr; WR_REQ_ADDR = addr; WR_REQ_LEN = 16'(len);
    RD_REQ_START = do_rd; RD_REQ_ADDR = addr; RD_REQ_LEN = 16'(len);
    @(negedge CLK);
    WR_REQ_START = 0;
    RD_REQ_START = 0;
    check("wr_ready_busy", WR_REQ_READY, 0);
    check("rd_ready_busy", RD_REQ_READY, 0);
    wait_idle(len * 3 + 200);
    check("aw_left", exp_aw.size(), 0);
    check("w_left", exp_w.size(), 0);
    check("ar_left", exp_ar.size(), 0);
    check("we_count", we_cnt, (do_rd && !do_wr) ? len / 4 : 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    logic [31:0] a;
    int unsigned l;
    bit          seen;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    RST_N = 0;
    WR_REQ_START = 0; RD_REQ_START = 0;
    WR_REQ_ADDR = '0; RD_REQ_ADDR = '0; WR_REQ_LEN = '0; RD_REQ_LEN = '0;
    repeat (3) @(negedge CLK);
    check("rst_wr_ready", WR_REQ_READY, 1);
    check("rst_rd_ready", RD_REQ_READY, 1);
    check("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, RD_REQ_MEM_WE,
                         M_AXI_BREADY, M_AXI_RREADY}, 0);
    check("rst_mem_addr", {WR_REQ_MEM_ADDR, RD_REQ_MEM_ADDR}, 0);
    RST_N = 1;

    // Full-memory fill from a page-aligned address.
    run_xfer(0, 1, 32'h0000_3000, 4096);
    // Full-memory write-back with random WREADY.
    run_xfer(1, 0, 32'h0000_8000, 4096);
    // Fill straddling a 4 KB page.
    run_xfer(0, 1, 32'h0000_0FF8, 16);
    // Zero-length requests produce no traffic.
    run_xfer(1, 0, 32'h0000_1000, 0);
    run_xfer(0, 1, 32'h0000_1000, 0);
    // Simultaneous starts: only the write runs.
    run_xfer(1, 1, 32'h0000_5F00, 1024);

    // Random requests, some forced near a page end.
    for (int k = 0; k < 8; k++) begin
      a = ($urandom & 32'h0000_FFFC) | 32'h0001_0000;
      if (k % 2 == 1) a = (a & 32'hFFFF_F000) | (32'h0000_1000 - 4 * $urandom_range(1, 40));
      l = 4 * $urandom_range(1, 400);
      run_xfer(($urandom_range(0, 1) == 1), 1, a, l);
    end

    // Reset in the middle of a write burst.
    build_exp(1, 32'h0000_2000, 64);
    @(negedge CLK);
    WR_REQ_START = 1; WR_REQ_ADDR = 32'h0000_2000; WR_REQ_LEN = 16'd64;
    @(negedge CLK);
    WR_REQ_START = 0;
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (M_AXI_WVALID) seen = 1;
      else @(negedge CLK);
    end
    check("wvalid_before_reset", seen, 1);
    RST_N = 0;
    @(posedge CLK);
    #2;
    exp_aw.delete(); exp_w.delete(); exp_ar.delete();
    pend_b = 0; r_pend = 0; b_hs = 0; r_hs = 0;
    M_AXI_BVALID = 0; M_AXI_RVALID = 0; M_AXI_RLAST = 0;
    @(negedge CLK);
    check("post_rst_wvalid", M_AXI_WVALID, 0);
    check("post_rst_ready", {WR_REQ_READY, RD_REQ_READY}, 2'b11);
    check("post_rst_awvalid", M_AXI_AWVALID, 0);
    check("post_rst_mem_addr", WR_REQ_MEM_ADDR, 0);
    RST_N = 1;
    run_xfer(1, 0, 32'h0000_2000, 4);

    repeat (5) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
